// File: rtl/csr_access_unit.sv
// csr_access_unit
//   Initiator side of the CSR read/write port. Executes one Zicsr instruction
//   (CSRRW/CSRRS/CSRRC and their immediate forms) per accepted request: reads
//   the old CSR value, computes the read-modify-write value, writes it back and
//   returns the old value for rd.
//
//   Handshakes: a transfer happens on any rising CLK edge where valid and ready
//   are both high. The initiator holds valid and its payload stable until that
//   edge. It does not wait for ready before raising valid. The request side
//   (req_valid/req_ready) and the response side (rsp_valid/rsp_ready) both
//   follow this rule. The csr_ren/csr_wen strobes are single-cycle commands
//   with no back-pressure.
//
//   Ports
//     CLK, RSTN      clock; asynchronous active-low reset
//     req_*          instruction request (funct3, addr, rs1 index/value, rd)
//     flush          kills a request still in READ (nothing written yet)
//     csr_ren/wen    read / write strobes toward the CSR file
//     csr_addr       registered CSR address
//     csr_wdata      registered write data
//     csr_rdata      combinational read data, valid while csr_ren is high
//     rsp_*          result: rd index, old CSR value, illegal flag
//     state_dbg      current FSM state (IDLE=0, READ=1, WRITE=2, RESP=3)
//
//   Timing: accept on cycle 0. csr_ren is high in cycle 1. csr_wen is high in
//   cycle 2. rsp_valid rises in cycle 3. An illegal request skips both strobe
//   cycles and goes straight to RESP.
module csr_access_unit #(
  parameter int XLEN     = 32,
  parameter int RO_CHECK = 1
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [11:0]     req_addr,
  input  logic [4:0]      req_rs1_idx,
  input  logic [XLEN-1:0] req_rs1_val,
  input  logic [4:0]      req_rd,
  input  logic            flush,
  output logic            csr_ren,
  output logic            csr_wen,
  output logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_wdata,
  input  logic [XLEN-1:0] csr_rdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [4:0]      rsp_rd,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_illegal,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state, state_n;

  // Fields captured at accept
  logic [2:0]      f3_q;
  logic [4:0]      rs1_idx_q;
  logic [XLEN-1:0] rs1_val_q;
  logic [4:0]      rd_q;
  logic            wr_sup_q;
  logic            rd_sup_q;
  logic [XLEN-1:0] old_q;

  // Decode of the incoming request
  logic accept;
  logic req_rd_sup;
  logic req_wr_sup;
  logic req_illegal;

  assign accept     = req_valid && req_ready;
  // CSRRW/CSRRWI with rd==x0 must not read (no read side effects).
  assign req_rd_sup = (req_funct3[1:0] == 2'b01) && (req_rd == 5'd0);
  // Set/clear forms with rs1/uimm==0 must not write.
  assign req_wr_sup = req_funct3[1] && (req_rs1_idx == 5'd0);
  // A set/clear that will not write may still read read-only space.
  assign req_illegal = (req_funct3[1:0] == 2'b00) ||
                       ((RO_CHECK != 0) && (req_addr[11:10] == 2'b11) && !req_wr_sup);

  // Read-modify-write datapath, evaluated during READ while csr_rdata is valid
  logic [XLEN-1:0] operand;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] new_val;

  always_comb begin
    operand = rs1_val_q;
    if (f3_q[2]) begin
      operand = {{(XLEN-5){1'b0}}, rs1_idx_q};
    end
    old_val = rd_sup_q ? '0 : csr_rdata;
    new_val = operand;
    case (f3_q[1:0])
      2'b10:   new_val = old_val | operand;
      2'b11:   new_val = old_val & ~operand;
      default: new_val = operand;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = req_illegal ? RESP : READ;
        end
      end
      READ: begin
        // Nothing committed yet, so a flush simply drops the request.
        state_n = flush ? IDLE : WRITE;
      end
      WRITE: begin
        state_n = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Registered outputs and captured request fields
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      req_ready   <= 1'b1;
      csr_ren     <= 1'b0;
      csr_wen     <= 1'b0;
      csr_addr    <= '0;
      csr_wdata   <= '0;
      rsp_valid   <= 1'b0;
      rsp_rd      <= '0;
      rsp_data    <= '0;
      rsp_illegal <= 1'b0;
      f3_q        <= '0;
      rs1_idx_q   <= '0;
      rs1_val_q   <= '0;
      rd_q        <= '0;
      wr_sup_q    <= 1'b0;
      rd_sup_q    <= 1'b0;
      old_q       <= '0;
    end else begin
      req_ready <= (state_n == IDLE);
      rsp_valid <= (state_n == RESP);
      csr_ren   <= (state == IDLE) && (state_n == READ) && !req_rd_sup;
      csr_wen   <= (state == READ) && (state_n == WRITE) && !wr_sup_q;

      if (accept) begin
        f3_q      <= req_funct3;
        rs1_idx_q <= req_rs1_idx;
        rs1_val_q <= req_rs1_val;
        rd_q      <= req_rd;
        wr_sup_q  <= req_wr_sup;
        rd_sup_q  <= req_rd_sup;
        csr_addr  <= req_addr;
      end

      if ((state == READ) && !flush) begin
        old_q     <= old_val;
        csr_wdata <= new_val;
      end

      if ((state == IDLE) && (state_n == RESP)) begin
        rsp_rd      <= '0;
        rsp_data    <= '0;
        rsp_illegal <= 1'b1;
      end else if (state == WRITE) begin
        rsp_rd      <= rd_q;
        rsp_data    <= old_q;
        rsp_illegal <= 1'b0;
      end
    end
  end

  assign state_dbg = state;

endmodule
